// File: rtl/hit_histogram.sv
// hit_histogram: X/Y projection histograms accumulated per window, frozen and served to the readout stage
module hit_histogram #(
  parameter int WINDOW_CYCLES    = 1000000,
  parameter int HOLD_TIMEOUT     = 1024,
  parameter int RETRY_LOW_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hit_valid,
  input  logic [6:0]  hit_x,
  input  logic [6:0]  hit_y,
  input  logic [6:0]  read_index_yaxis,
  input  logic [6:0]  read_index_xaxis,
  output logic        start_sending,
  output logic [15:0] data_yaxis,
  output logic [15:0] data_xaxis,
  output logic [15:0] frame_count,
  output logic [15:0] dropped_hits,
  output logic        saturated
);
  typedef enum logic [1:0] {CLEAR, ACCUM, HOLD, RETRY} state_t;
  localparam int WW = $clog2(WINDOW_CYCLES + 1);
  localparam int TW = $clog2(HOLD_TIMEOUT + 1);
  localparam int RW = $clog2(RETRY_LOW_CYCLES + 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW_CYCLES - 1);
  localparam logic [TW-1:0] TO_LIMIT   = TW'(HOLD_TIMEOUT);
  localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_LOW_CYCLES - 1);
  logic [15:0] x_count_q [128];
  logic [15:0] y_count_q [128];
  state_t state_q, state_d;
  logic [6:0] clear_idx_q, clear_idx_d;
  logic [WW-1:0] win_q, win_d;
  logic [TW-1:0] to_q, to_d;
  logic [RW-1:0] rc_q, rc_d;
  logic seen_top_q, seen_top_d;
  logic start_sending_q, start_sending_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] dropped_hits_q, dropped_hits_d;
  logic saturated_q, saturated_d;
  logic [15:0] x_cur, y_cur, x_inc, y_inc, x_wd, y_wd;
  logic [6:0] x_wa, y_wa;
  logic cnt_we;
  assign start_sending = start_sending_q;
  assign frame_count   = frame_count_q;
  assign dropped_hits  = dropped_hits_q;
  assign saturated     = saturated_q;
  assign data_xaxis    = x_count_q[read_index_xaxis];
  assign data_yaxis    = y_count_q[read_index_yaxis];
  // Count write port: CLEAR walks zeros through the arrays, ACCUM does a saturating increment per axis.
  always_comb begin
    x_cur  = x_count_q[hit_x];
    y_cur  = y_count_q[hit_y];
    x_inc  = (x_cur == 16'hFFFF) ? x_cur : x_cur + 16'd1;
    y_inc  = (y_cur == 16'hFFFF) ? y_cur : y_cur + 16'd1;
    cnt_we = (state_q == CLEAR) || (state_q == ACCUM && hit_valid);
    x_wa   = (state_q == CLEAR) ? clear_idx_q : hit_x;
    y_wa   = (state_q == CLEAR) ? clear_idx_q : hit_y;
    x_wd   = (state_q == CLEAR) ? 16'd0 : x_inc;
    y_wd   = (state_q == CLEAR) ? 16'd0 : y_inc;
  end
  // Count arrays carry no reset; CLEAR is what initialises them each frame.
  always_ff @(posedge clk) begin
    if (cnt_we) begin
      x_count_q[x_wa] <= x_wd;
      y_count_q[y_wa] <= y_wd;
    end
  end
  // Frame sequencing: clear, accumulate, hold for readout (with retry pulse), repeat.
  always_comb begin
    state_d         = state_q;
    clear_idx_d     = clear_idx_q;
    win_d           = win_q;
    to_d            = to_q;
    rc_d            = rc_q;
    seen_top_d      = seen_top_q;
    start_sending_d = start_sending_q;
    frame_count_d   = frame_count_q;
    saturated_d     = saturated_q;
    dropped_hits_d  = (hit_valid && state_q != ACCUM && dropped_hits_q != 16'hFFFF) ? dropped_hits_q + 16'd1 : dropped_hits_q;
    case (state_q)
      CLEAR: begin
        clear_idx_d = clear_idx_q + 7'd1;
        if (clear_idx_q == 7'd127) begin
          state_d     = ACCUM;
          win_d       = '0;
          saturated_d = 1'b0;
        end
      end
      ACCUM: begin
        win_d = win_q + WW'(1);
        if (hit_valid && (x_inc == 16'hFFFF || y_inc == 16'hFFFF)) saturated_d = 1'b1;
        if (win_q == WIN_LAST) begin
          state_d         = HOLD;
          win_d           = '0;
          start_sending_d = 1'b1;
          seen_top_d      = 1'b0;
          to_d            = '0;
        end
      end
      HOLD: begin
        to_d = to_q + TW'(1);
        if (read_index_yaxis == 7'd127) seen_top_d = 1'b1;
        if (seen_top_q && read_index_yaxis == 7'd0) begin
          state_d         = CLEAR;
          clear_idx_d     = '0;
          start_sending_d = 1'b0;
          frame_count_d   = frame_count_q + 16'd1;
        end else if (!seen_top_q && to_d == TO_LIMIT) begin
          state_d         = RETRY;
          start_sending_d = 1'b0;
          rc_d            = '0;
        end
      end
      default: begin
        rc_d = rc_q + RW'(1);
        if (rc_q == RETRY_LAST) begin
          state_d         = HOLD;
          start_sending_d = 1'b1;
          to_d            = '0;
        end
      end
    endcase
  end
  // Control and status registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= CLEAR;
      clear_idx_q     <= '0;
      win_q           <= '0;
      to_q            <= '0;
      rc_q            <= '0;
      seen_top_q      <= 1'b0;
      start_sending_q <= 1'b0;
      frame_count_q   <= '0;
      dropped_hits_q  <= '0;
      saturated_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      clear_idx_q     <= clear_idx_d;
      win_q           <= win_d;
      to_q            <= to_d;
      rc_q            <= rc_d;
      seen_top_q      <= seen_top_d;
      start_sending_q <= start_sending_d;
      frame_count_q   <= frame_count_d;
      dropped_hits_q  <= dropped_hits_d;
      saturated_q     <= saturated_d;
    end
  end
endmodule

// File: tb/tb_hit_histogram.sv
// tb_hit_histogram: table/scoreboard bench for hit_histogram with a second instance for saturation
module tb_hit_histogram;
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_n, hv;
  logic [6:0] hx, hy, rx, ry;
  logic st, sat;
  logic [15:0] dx, dy, fc, dh;

  logic s_rst_n, s_hv, s_st, s_sat, s_done;
  logic [6:0] s_hx, s_hy, s_rx, s_ry;
  logic [15:0] s_dx, s_dy, s_fc, s_dh;

  hit_histogram #(.WINDOW_CYCLES(16), .HOLD_TIMEOUT(8), .RETRY_LOW_CYCLES(4)) u_dut (
    .clk(clk), .reset(rst_n), .hit_valid(hv), .hit_x(hx), .hit_y(hy),
    .read_index_yaxis(ry), .read_index_xaxis(rx), .start_sending(st),
    .data_yaxis(dy), .data_xaxis(dx), .frame_count(fc), .dropped_hits(dh), .saturated(sat));

  hit_histogram #(.WINDOW_CYCLES(65540), .HOLD_TIMEOUT(8), .RETRY_LOW_CYCLES(4)) u_sat (
    .clk(clk), .reset(s_rst_n), .hit_valid(s_hv), .hit_x(s_hx), .hit_y(s_hy),
    .read_index_yaxis(s_ry), .read_index_xaxis(s_rx), .start_sending(s_st),
    .data_yaxis(s_dy), .data_xaxis(s_dx), .frame_count(s_fc), .dropped_hits(s_dh), .saturated(s_sat));

  typedef struct packed { logic v; logic [6:0] x; logic [6:0] y; } hit_vec_t;
  typedef struct packed { logic [6:0] ix; logic [6:0] iy; logic [15:0] ex; logic [15:0] ey; } spot_t;
  typedef struct packed { logic [15:0] ex; logic [15:0] ey; } rd_exp_t;

  hit_vec_t acc_tab [16];
  spot_t    spot_tab [4];
  rd_exp_t  sb [$];
  logic [15:0] mx [128];
  logic [15:0] my [128];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input int n_hits);
    for (int t = 0; t < 128; t++) begin
      hv = (t < n_hits);
      hx = 7'd3;
      hy = 7'd100;
      tick();
    end
    hv = 1'b0;
    for (int i = 0; i < 128; i++) begin
      mx[i] = 16'd0;
      my[i] = 16'd0;
    end
  endtask

  task automatic run_accum(input logic use_tab);
    for (int t = 0; t < 16; t++) begin
      if (t == 15) chk("start_before_window_end", st, 0);
      hv = use_tab ? acc_tab[t].v : 1'b0;
      hx = acc_tab[t].x;
      hy = acc_tab[t].y;
      if (hv) begin
        mx[hx] = mx[hx] + 16'd1;
        my[hy] = my[hy] + 16'd1;
      end
      tick();
    end
    hv = 1'b0;
    chk("start_rise", st, 1);
  endtask

  task automatic sweep(input int n_drop_hits);
    rd_exp_t e;
    for (int i = 127; i >= 0; i--) begin
      rx = 7'(i);
      ry = 7'(i);
      hv = ((127 - i) < n_drop_hits);
      hx = 7'd3;
      hy = 7'd100;
      sb.push_back('{mx[i], my[i]});
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("sweep_x[%0d]", i), dx, e.ex);
      chk($sformatf("sweep_y[%0d]", i), dy, e.ey);
      tick();
    end
    hv = 1'b0;
    rx = 7'd0;
    ry = 7'd0;
    chk("start_fall_after_sweep", st, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_rst_n = 1'b0; s_hv = 1'b0; s_hx = 7'd9; s_hy = 7'd20; s_rx = 7'd9; s_ry = 7'd20; s_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    s_rst_n = 1'b1;
    repeat (128) tick();
    s_hv = 1'b1;
    repeat (65534) tick();
    chk("sat_pre_x", s_dx, 16'hFFFE);
    chk("sat_pre_y", s_dy, 16'hFFFE);
    chk("sat_pre_flag", s_sat, 0);
    repeat (3) tick();
    s_hv = 1'b0;
    chk("sat_x", s_dx, 16'hFFFF);
    chk("sat_y", s_dy, 16'hFFFF);
    chk("sat_flag", s_sat, 1);
    repeat (3) tick();
    chk("sat_start", s_st, 1);
    chk("sat_flag_hold", s_sat, 1);
    chk("sat_dropped", s_dh, 0);
    s_ry = 7'd127;
    tick();
    s_ry = 7'd0;
    tick();
    chk("sat_start_fall", s_st, 0);
    chk("sat_frame_count", s_fc, 1);
    repeat (127) tick();
    chk("sat_flag_in_clear", s_sat, 1);
    tick();
    chk("sat_flag_cleared_on_accum", s_sat, 0);
    s_ry = 7'd20;
    #1;
    chk("sat_x_cleared", s_dx, 0);
    chk("sat_y_cleared", s_dy, 0);
    s_done = 1'b1;
  end

  initial begin
    rd_exp_t e;
    rst_n = 1'b0; hv = 1'b0; hx = 7'd0; hy = 7'd0; rx = 7'd0; ry = 7'd0;
    for (int t = 0; t < 16; t++) acc_tab[t] = '{1'b0, 7'd0, 7'd0};
    for (int t = 0; t < 4; t++) acc_tab[t] = '{1'b1, 7'd3, 7'd100};
    acc_tab[10] = '{1'b1, 7'd127, 7'd0};
    acc_tab[15] = '{1'b1, 7'd3, 7'd100};
    spot_tab[0] = '{7'd3,   7'd100, 16'd5, 16'd5};
    spot_tab[1] = '{7'd127, 7'd0,   16'd1, 16'd1};
    spot_tab[2] = '{7'd100, 7'd3,   16'd0, 16'd0};
    spot_tab[3] = '{7'd0,   7'd127, 16'd0, 16'd0};
    for (int i = 0; i < 128; i++) begin
      mx[i] = 16'd0;
      my[i] = 16'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_start", st, 0);
    chk("reset_frame_count", fc, 0);
    chk("reset_dropped", dh, 0);
    chk("reset_saturated", sat, 0);
    rst_n = 1'b1;
    do_clear(0);
    run_accum(1'b0);
    sweep(0);
    chk("frame_count_1", fc, 1);
    do_clear(0);
    run_accum(1'b1);
    for (int k = 0; k < 4; k++) begin
      rx = spot_tab[k].ix;
      ry = spot_tab[k].iy;
      sb.push_back('{spot_tab[k].ex, spot_tab[k].ey});
      #1;
      e = sb.pop_front();
      chk($sformatf("spot_x[%0d]", spot_tab[k].ix), dx, e.ex);
      chk($sformatf("spot_y[%0d]", spot_tab[k].iy), dy, e.ey);
    end
    sweep(4);
    chk("frame_count_2", fc, 2);
    do_clear(3);
    chk("dropped_hits_7", dh, 7);
    chk("saturated_clear", sat, 0);
    run_accum(1'b0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("timeout_high_%0d", k), st, 1);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("retry_low_%0d", k), st, 0);
      tick();
    end
    chk("retry_rise", st, 1);
    sweep(0);
    chk("frame_count_3", fc, 3);
    do_clear(0);
    for (int t = 0; t < 5; t++) begin
      hv = acc_tab[t].v;
      hx = acc_tab[t].x;
      hy = acc_tab[t].y;
      tick();
    end
    hv = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("accum_reset_start", st, 0);
    chk("accum_reset_frame_count", fc, 0);
    chk("accum_reset_dropped", dh, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_clear(0);
    run_accum(1'b1);
    rst_n = 1'b0;
    #1;
    chk("hold_reset_start_drop", st, 0);
    chk("hold_reset_frame_count", fc, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_clear(0);
    run_accum(1'b0);
    sweep(0);
    chk("frame_count_after_reset", fc, 1);
    wait (s_done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
